// File: rtl/btb_assoc_pkg.sv
// Shared types and tree-PLRU helpers for the set-associative branch target buffer.
// Tree bits use heap order (node n has children 2n+1 / 2n+2); a bit value of 1 steers the victim right.
package btb_assoc_pkg;

    localparam int MAX_TAG_W = 30;
    localparam int MAX_LVL   = 3;

    typedef struct packed {
        logic [MAX_TAG_W-1:0] tag;
        logic [31:0]          target;
    } btb_entry_t;

    function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int levels);
        logic [2:0] node;
        logic [2:0] way;
        node = '0;
        way  = '0;
        for (int l = 0; l < MAX_LVL; l++) begin
            if (l < levels) begin
                way  = {way[1:0], bits[node]};
                node = {node[1:0], 1'b0} + 3'd1 + {2'b00, bits[node]};
            end
        end
        return way;
    endfunction

    function automatic logic [6:0] plru_touch(input logic [6:0] bits, input logic [2:0] way,
                                              input int levels);
        logic [6:0] nb;
        logic [2:0] node;
        logic [2:0] sh;
        logic       b;
        nb   = bits;
        node = '0;
        for (int l = 0; l < MAX_LVL; l++) begin
            if (l < levels) begin
                sh       = way >> (levels - 1 - l);
                b        = sh[0];
                nb[node] = ~b;
                node     = {node[1:0], 1'b0} + 3'd1 + {2'b00, b};
            end
        end
        return nb;
    endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup ports plus retire-side update/invalidate/flush controls of the BTB.
interface btb_assoc_if #(
    parameter int RD_PORTS = 2
);
    logic [RD_PORTS-1:0][31:0] pc_in;
    logic [RD_PORTS-1:0]       hit;
    logic [RD_PORTS-1:0][31:0] next_pc;
    logic                      wr_en;
    logic [31:0]               orig_pc;
    logic [31:0]               target_pc;
    logic                      invalidate;
    logic [31:0]               pc_invalid;
    logic                      flush;

    modport master (
        output pc_in, wr_en, orig_pc, target_pc, invalidate, pc_invalid, flush,
        input  hit, next_pc
    );

    modport slave (
        input  pc_in, wr_en, orig_pc, target_pc, invalidate, pc_invalid, flush,
        output hit, next_pc
    );
endinterface

// File: rtl/btb_assoc_plru.sv
// Per-set tree-PLRU state: applies the write touch, then hit touches from the last port down to port 0.
module btb_assoc_plru
    import btb_assoc_pkg::*;
#(
    parameter int SETS     = 256,
    parameter int WAYS     = 4,
    parameter int RD_PORTS = 2,
    parameter int SET_BITS = $clog2(SETS),
    parameter int WW       = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_flush,
    input  logic                              i_wr_touch,
    input  logic [SET_BITS-1:0]               i_wr_set,
    input  logic [WW-1:0]                     i_wr_way,
    input  logic [RD_PORTS-1:0]               i_hit_touch,
    input  logic [RD_PORTS-1:0][SET_BITS-1:0] i_hit_set,
    input  logic [RD_PORTS-1:0][WW-1:0]       i_hit_way,
    output logic [WW-1:0]                     o_victim
);

    localparam int LVL = (WAYS > 1) ? $clog2(WAYS) : 0;
    localparam int PB  = (WAYS > 1) ? WAYS - 1 : 1;

    generate
        if (WAYS == 1) begin : g_direct
            logic w_unused_touch;
            assign w_unused_touch = ^{clk, rst_n, i_flush, i_wr_touch, i_wr_set, i_wr_way,
                                      i_hit_touch, i_hit_set, i_hit_way};
            assign o_victim = '0;
        end else begin : g_tree
            logic [PB-1:0] r_bits [SETS];
            logic [PB-1:0] w_next [SETS];

            function automatic logic [6:0] widen(input logic [PB-1:0] b);
                logic [6:0] t;
                t         = '0;
                t[PB-1:0] = b;
                return t;
            endfunction

            function automatic logic [PB-1:0] touch(input logic [PB-1:0] b, input logic [WW-1:0] w);
                return PB'(plru_touch(widen(b), 3'(w), LVL));
            endfunction

            // Touches to the same set compose in order because each reads the previous result.
            always_comb begin
                // NOTE: every always_comb output gets a full default first so no path leaves it unassigned (no latch).
                w_next = r_bits;
                if (i_wr_touch)
                    w_next[i_wr_set] = touch(w_next[i_wr_set], i_wr_way);
                for (int p = RD_PORTS - 1; p >= 0; p--) begin
                    if (i_hit_touch[p])
                        w_next[i_hit_set[p]] = touch(w_next[i_hit_set[p]], i_hit_way[p]);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n || i_flush) begin
                    for (int s = 0; s < SETS; s++) r_bits[s] <= '0;
                end else begin
                    r_bits <= w_next;
                end
            end

            assign o_victim = WW'(plru_victim(widen(r_bits[i_wr_set]), LVL));
        end
    endgenerate

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: combinational multi-port lookup, single install/refresh port,
// single-entry invalidate and global flush, with tree-PLRU replacement per set.
module btb_assoc
    import btb_assoc_pkg::*;
#(
    parameter int SETS     = 256,
    parameter int WAYS     = 4,
    parameter int RD_PORTS = 2,
    parameter int TAG_W    = 30 - $clog2(SETS)
) (
    input  logic        clk,
    input  logic        rst_n,
    btb_assoc_if.slave  bus
);

    localparam int SET_BITS = $clog2(SETS);
    localparam int WW       = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef logic [SET_BITS-1:0]  set_t;
    typedef logic [MAX_TAG_W-1:0] tag_t;
    typedef logic [WW-1:0]        way_t;

    function automatic set_t pc_set(input logic [31:0] pc);
        return pc[SET_BITS+1:2];
    endfunction

    function automatic tag_t pc_tag(input logic [31:0] pc);
        return tag_t'(pc[SET_BITS+2 +: TAG_W]);
    endfunction

    logic [WAYS-1:0] r_valid [SETS];
    btb_entry_t      r_mem   [WAYS][SETS];

    logic [WAYS-1:0]                   w_rd_match [RD_PORTS];
    logic [RD_PORTS-1:0]               w_hit;
    logic [RD_PORTS-1:0][31:0]         w_next_pc;
    logic [RD_PORTS-1:0][SET_BITS-1:0] w_hit_set;
    logic [RD_PORTS-1:0][WW-1:0]       w_hit_way;

    // Lookup: one-hot way match, AND-OR muxed target (zero on miss).
    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            w_rd_match[p] = '0;
            w_hit_way[p]  = '0;
            w_next_pc[p]  = '0;
            w_hit_set[p]  = pc_set(bus.pc_in[p]);
            for (int w = 0; w < WAYS; w++) begin
                if (r_valid[w_hit_set[p]][w] &&
                    r_mem[w][w_hit_set[p]].tag == pc_tag(bus.pc_in[p])) begin
                    w_rd_match[p][w] = 1'b1;
                    w_hit_way[p]     = w_hit_way[p] | way_t'(w);
                    w_next_pc[p]     = w_next_pc[p] | r_mem[w][w_hit_set[p]].target;
                end
            end
            w_hit[p] = |w_rd_match[p];
        end
    end

    assign bus.hit     = w_hit;
    assign bus.next_pc = w_next_pc;

    set_t            w_wr_set, w_inv_set;
    tag_t            w_wr_tag, w_inv_tag;
    logic [WAYS-1:0] w_wr_match, w_inv_match;
    way_t            w_wr_match_way, w_inv_way, w_free_way, w_plru_victim, w_victim_way, w_wr_way;
    logic            w_has_free, w_wr_hit, w_inv_hit, w_suppress, w_wr_do;

    assign w_wr_set  = pc_set(bus.orig_pc);
    assign w_wr_tag  = pc_tag(bus.orig_pc);
    assign w_inv_set = pc_set(bus.pc_invalid);
    assign w_inv_tag = pc_tag(bus.pc_invalid);

    // Descending scan so the lowest-index free way is the one left selected.
    always_comb begin
        w_wr_match     = '0;
        w_inv_match    = '0;
        w_wr_match_way = '0;
        w_inv_way      = '0;
        w_free_way     = '0;
        w_has_free     = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_wr_set][w] && r_mem[w][w_wr_set].tag == w_wr_tag) begin
                w_wr_match[w]  = 1'b1;
                w_wr_match_way = way_t'(w);
            end
            if (r_valid[w_inv_set][w] && r_mem[w][w_inv_set].tag == w_inv_tag) begin
                w_inv_match[w] = 1'b1;
                w_inv_way      = way_t'(w);
            end
            if (!r_valid[w_wr_set][w]) begin
                w_has_free = 1'b1;
                w_free_way = way_t'(w);
            end
        end
    end

    assign w_wr_hit   = |w_wr_match;
    assign w_inv_hit  = bus.invalidate && (|w_inv_match);
    assign w_suppress = bus.invalidate && (w_inv_set == w_wr_set) && (w_inv_tag == w_wr_tag);
    assign w_wr_do    = bus.wr_en && !bus.flush && !w_suppress;

    // Never evict the way being invalidated this cycle; its PLRU sibling takes the install instead.
    always_comb begin
        w_victim_way = w_plru_victim;
        if (WAYS > 1 && w_inv_hit && w_inv_set == w_wr_set && w_plru_victim == w_inv_way)
            w_victim_way = w_plru_victim ^ way_t'(1);
    end

    assign w_wr_way = w_wr_hit   ? w_wr_match_way :
                      w_has_free ? w_free_way     : w_victim_way;

    // NOTE: non-blocking assignments: all state sees pre-edge values, and the later write to the same valid bit wins.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
        end else begin
            if (w_inv_hit) r_valid[w_inv_set][w_inv_way] <= 1'b0;
            if (w_wr_do)   r_valid[w_wr_set][w_wr_way]   <= 1'b1;
        end
    end

    // NOTE: tag/target storage has no reset; the valid array alone makes stale contents invisible.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_do)
            r_mem[w_wr_way][w_wr_set] <= '{tag: w_wr_tag, target: bus.target_pc};
    end

    btb_assoc_plru #(
        .SETS     (SETS),
        .WAYS     (WAYS),
        .RD_PORTS (RD_PORTS),
        .SET_BITS (SET_BITS),
        .WW       (WW)
    ) u_plru (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (bus.flush),
        .i_wr_touch  (w_wr_do),
        .i_wr_set    (w_wr_set),
        .i_wr_way    (w_wr_way),
        .i_hit_touch (w_hit),
        .i_hit_set   (w_hit_set),
        .i_hit_way   (w_hit_way),
        .o_victim    (w_plru_victim)
    );

    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{bus.pc_in, bus.orig_pc, bus.pc_invalid};

    generate
        for (genvar p = 0; p < RD_PORTS; p++) begin : g_onehot
            a_rd_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_rd_match[p]));
        end
    endgenerate

    a_wr_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_wr_match));

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc (4 sets, 2 ways, 2 lookup ports): directed scenarios plus
// random traffic, all compared against a per-set LRU reference model (2-way tree PLRU equals LRU).
module tb_btb_assoc;

    localparam int SETS  = 4;
    localparam int WAYS  = 2;
    localparam int RD    = 2;
    localparam int TAG_W = 28;
    localparam logic [31:0] IDLE_PC = 32'h0000_0FFC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btb_assoc_if #(.RD_PORTS(RD)) bus ();

    btb_assoc #(
        .SETS     (SETS),
        .WAYS     (WAYS),
        .RD_PORTS (RD),
        .TAG_W    (TAG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per set, WAYS slots and the index of the least recently touched slot.
    bit          m_valid [SETS][WAYS];
    logic [27:0] m_tag   [SETS][WAYS];
    logic [31:0] m_tgt   [SETS][WAYS];
    int          m_lru   [SETS];
    bit          m_known = 1'b0;

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc >> 2) % SETS);
    endfunction

    function automatic logic [27:0] tag_of(input logic [31:0] pc);
        return 28'(pc >> 4);
    endfunction

    function automatic int find(input int s, input logic [27:0] t);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic model_cycle();
        int hs [RD];
        int hw [RD];
        int ws, is, iw, way;
        bit sup;
        for (int p = 0; p < RD; p++) begin
            hs[p] = set_of(bus.pc_in[p]);
            hw[p] = find(hs[p], tag_of(bus.pc_in[p]));
            if (m_known) begin
                check($sformatf("model_p%0d_hit", p), 32'(bus.hit[p]), (hw[p] >= 0) ? 32'd1 : 32'd0);
                check($sformatf("model_p%0d_pc", p), bus.next_pc[p],
                      (hw[p] >= 0) ? m_tgt[hs[p]][hw[p]] : 32'd0);
            end
        end
        if (!rst_n) begin
            model_clear();
            m_known = 1'b1;
            return;
        end
        if (bus.flush) begin
            model_clear();
            return;
        end
        ws  = set_of(bus.orig_pc);
        is  = set_of(bus.pc_invalid);
        iw  = bus.invalidate ? find(is, tag_of(bus.pc_invalid)) : -1;
        sup = bus.invalidate && is == ws && tag_of(bus.pc_invalid) == tag_of(bus.orig_pc);
        way = -1;
        if (bus.wr_en && !sup) begin
            way = find(ws, tag_of(bus.orig_pc));
            if (way < 0)
                for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[ws][w]) way = w;
            if (way < 0) begin
                way = m_lru[ws];
                if (is == ws && way == iw) way = 1 - way;
            end
        end
        if (iw >= 0) m_valid[is][iw] = 1'b0;
        if (way >= 0) begin
            m_valid[ws][way] = 1'b1;
            m_tag[ws][way]   = tag_of(bus.orig_pc);
            m_tgt[ws][way]   = bus.target_pc;
            m_lru[ws]        = 1 - way;
        end
        for (int p = RD - 1; p >= 0; p--)
            if (hw[p] >= 0) m_lru[hs[p]] = 1 - hw[p];
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pc_in[0]   = IDLE_PC;
        bus.pc_in[1]   = IDLE_PC;
        bus.wr_en      = 1'b0;
        bus.orig_pc    = '0;
        bus.target_pc  = '0;
        bus.invalidate = 1'b0;
        bus.pc_invalid = '0;
        bus.flush      = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic write(input logic [31:0] pc, input logic [31:0] tgt);
        idle();
        bus.wr_en     = 1'b1;
        bus.orig_pc   = pc;
        bus.target_pc = tgt;
        tick();
        idle();
    endtask

    task automatic look(input int p, input logic [31:0] pc, input logic exp_hit,
                        input logic [31:0] exp_pc, input string tag);
        bus.pc_in[p] = pc;
        #1;
        check({tag, "_hit"}, 32'(bus.hit[p]), 32'(exp_hit));
        check({tag, "_pc"}, bus.next_pc[p], exp_pc);
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] t;
        t = $urandom_range(0, 5);
        if ($urandom_range(0, 3) == 0) t = t | 32'h0800_0000;
        return (t << 4) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        // 1: reset state, install, same-cycle lookup sees the old state
        do_reset();
        look(0, 32'h100, 1'b0, 32'h0, "s1_rst_p0");
        look(1, 32'h104, 1'b0, 32'h0, "s1_rst_p1");
        tick();
        idle();
        bus.wr_en = 1'b1; bus.orig_pc = 32'h100; bus.target_pc = 32'h2000;
        look(0, 32'h100, 1'b0, 32'h0, "s1_same_cycle");
        tick();
        idle();
        look(0, 32'h100, 1'b1, 32'h2000, "s1_installed");
        tick();
        idle();

        // 2: fill set 0, touch 0x100, then a third tag evicts 0x200
        do_reset();
        write(32'h100, 32'hA);
        write(32'h200, 32'hB);
        look(0, 32'h100, 1'b1, 32'hA, "s2_touch");
        tick();
        write(32'h300, 32'hC);
        look(0, 32'h100, 1'b1, 32'hA, "s2_keep");
        look(1, 32'h300, 1'b1, 32'hC, "s2_new");
        tick();
        idle();
        look(0, 32'h200, 1'b0, 32'h0, "s2_evicted");
        tick();
        idle();

        // 3: refresh reuses the way, second tag fills the free way
        do_reset();
        write(32'h100, 32'hA);
        write(32'h100, 32'hD);
        look(0, 32'h100, 1'b1, 32'hD, "s3_refresh");
        tick();
        write(32'h200, 32'hB);
        look(0, 32'h100, 1'b1, 32'hD, "s3_kept");
        look(1, 32'h200, 1'b1, 32'hB, "s3_second");
        tick();
        idle();

        // 4: invalidate + write of the same entry, then an absent invalidate
        do_reset();
        write(32'h100, 32'hA);
        bus.invalidate = 1'b1; bus.pc_invalid = 32'h100;
        bus.wr_en = 1'b1; bus.orig_pc = 32'h100; bus.target_pc = 32'hE;
        tick();
        idle();
        look(0, 32'h100, 1'b0, 32'h0, "s4_suppressed");
        tick();
        write(32'h200, 32'hB);
        write(32'h100, 32'hA);
        bus.invalidate = 1'b1; bus.pc_invalid = 32'h500;
        tick();
        idle();
        look(0, 32'h200, 1'b1, 32'hB, "s4_absent_a");
        look(1, 32'h100, 1'b1, 32'hA, "s4_absent_b");
        tick();
        idle();

        // 5: flush drops the same-cycle write
        do_reset();
        write(32'h100, 32'hA);
        bus.flush = 1'b1; bus.wr_en = 1'b1; bus.orig_pc = 32'h104; bus.target_pc = 32'hF;
        tick();
        idle();
        look(0, 32'h100, 1'b0, 32'h0, "s5_old");
        look(1, 32'h104, 1'b0, 32'h0, "s5_dropped");
        tick();
        idle();

        // 6: dual hit leaves port 0 MRU; reset discards a write
        do_reset();
        write(32'h100, 32'hA);
        write(32'h200, 32'hB);
        look(0, 32'h100, 1'b1, 32'hA, "s6_dual_p0");
        look(1, 32'h200, 1'b1, 32'hB, "s6_dual_p1");
        tick();
        write(32'h300, 32'hC);
        look(0, 32'h100, 1'b1, 32'hA, "s6_p0_kept");
        look(1, 32'h200, 1'b0, 32'h0, "s6_p1_evicted");
        tick();
        idle();
        rst_n = 1'b0;
        bus.wr_en = 1'b1; bus.orig_pc = 32'h104; bus.target_pc = 32'hF;
        tick();
        rst_n = 1'b1;
        idle();
        look(0, 32'h104, 1'b0, 32'h0, "s6_rst_write");
        look(1, 32'h300, 1'b0, 32'h0, "s6_rst_clear");
        tick();

        // Random traffic on a small PC pool so sets fill, conflict and collide.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n          = ($urandom_range(0, 99) != 0);
            bus.flush      = ($urandom_range(0, 99) < 3);
            bus.wr_en      = ($urandom_range(0, 1) == 1);
            bus.orig_pc    = rpc();
            bus.target_pc  = $urandom;
            bus.invalidate = ($urandom_range(0, 3) == 0);
            bus.pc_invalid = ($urandom_range(0, 2) == 0) ? bus.orig_pc : rpc();
            bus.pc_in[0]   = rpc();
            bus.pc_in[1]   = rpc();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
